// File: rtl/sr_q_edge_monitor.sv
// Edge monitor for the SR flip-flop Q output: queues {direction, run length} events in a small FIFO
// and keeps rise/fall counters plus a sticky overflow flag. Define SRQ_MON_SYNC_EN to add a 2-flop input synchronizer.
module sr_q_edge_monitor #(
    parameter int WIDTH_W = 16,
    parameter int CNT_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_in,
    input  logic               clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic               evt_rise,
    output logic [WIDTH_W-1:0] evt_width,
    output logic [CNT_W-1:0]   rise_cnt,
    output logic [CNT_W-1:0]   fall_cnt,
    output logic               ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [WIDTH_W-1:0] RUN_MAX = '1;

    function automatic logic [WIDTH_W-1:0] sat_inc(input logic [WIDTH_W-1:0] v);
        return (v == RUN_MAX) ? v : v + 1'b1;
    endfunction

    logic               q_s;
    logic               run_en;
    logic               q_d;
    logic [WIDTH_W-1:0] run_len;
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [WIDTH_W:0]   mem [DEPTH];
    logic [WIDTH_W:0]   head_hold;
    logic [WIDTH_W:0]   head;
    logic               empty;
    logic               full;
    logic               pop;
    logic               edge_det;
    logic               push;

`ifdef SRQ_MON_SYNC_EN
    logic sync_p0;
    logic sync_p1;
    logic vld_p0;
    logic vld_p1;

    // Synchronizer stage: run length only counts once real samples reach q_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sync_p0 <= q_in;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
        end
    end

    assign q_s    = sync_p1;
    assign run_en = vld_p1;
`else
    assign q_s    = q_in;
    assign run_en = 1'b1;
`endif

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign evt_valid = ~empty;
    assign pop      = evt_valid & evt_ready;
    assign edge_det = q_s ^ q_d;
    // A full FIFO still accepts an edge when the consumer frees the head in the same cycle.
    assign push     = edge_det & (~full | pop);

    assign head = evt_valid ? mem[rd_ptr[PTR_W-1:0]] : head_hold;
    assign {evt_rise, evt_width} = head;

    always_ff @(posedge clk) begin
        if (!clr && push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {q_s, run_len};
        end
    end

    // Edge detect / queue stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_d       <= 1'b0;
            run_len   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_hold <= '0;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            q_d <= q_s;
            if (clr) begin
                run_len  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rise_cnt <= '0;
                fall_cnt <= '0;
                ovf      <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    head_hold <= mem[rd_ptr[PTR_W-1:0]];
                end
                if (edge_det) begin
                    run_len <= {{(WIDTH_W-1){1'b0}}, 1'b1};
                    if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (q_s) begin
                            rise_cnt <= rise_cnt + 1'b1;
                        end else begin
                            fall_cnt <= fall_cnt + 1'b1;
                        end
                    end else begin
                        ovf <= 1'b1;
                    end
                end else if (run_en) begin
                    run_len <= sat_inc(run_len);
                end
            end
        end
    end

endmodule
